multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, the maximum number of wait cycles on a memory handshake before a fault (range 0..255, 0 = no timeout).
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 OpCode  input  6  instr[31:26] from the instruction register; valid from DECODE onward.
REQ-005 mem_ready  input  1  memory completion strobe for the current mem_req.
REQ-006 mem_req  output  1  memory access request.
REQ-007 IorD  output  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-008 IR_WE  output  1  instruction register write enable.
REQ-009 PC_WE  output  1  unconditional PC write enable.
REQ-010 Branch  output  1  conditional PC write (datapath ANDs it with ALU zero).
REQ-011 PC_Src  output  2  next-PC source: 00 = ALU, 01 = ALU result register (branch target), 10 = jump target.
REQ-012 ALU_SrcA  output  1  ALU A input: 0 = PC, 1 = rs.
REQ-013 ALU_SrcB  output  2  ALU B input: 00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2.
REQ-014 Operation  output  3  ALU op class: 000 = add, 001 = subtract, 010 = decode by funct.
REQ-015 WE_DM  output  1  data memory write enable.
REQ-016 RF_WE  output  1  register file write enable.
REQ-017 RF_WA_Sel  output  2  write address: 00 = rt, 01 = rd, 10 = register 31.
REQ-018 WD_Sel  output  2  register file write data: 00 = ALU result register, 01 = memory data register, 10 = PC.
REQ-019 instr_done  output  1  one-cycle pulse in the final state of each instruction.
REQ-020 fault  output  1  sticky error flag.
REQ-021 state  output  4  current state encoding, for debug.

Function
REQ-022 Moore FSM, outputs a function of state and mem_ready only; every output not listed for a state SHALL be 0.
REQ-023 State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXE=6, ALUWB=7, BEQ=8, ADDIEXE=9, ADDIWB=10, JUMP=11, JAL=12, FAULT=15.
REQ-024 FETCH: mem_req=1, IorD=0, ALU_SrcB=01, Operation=000; when mem_ready=1, IR_WE=1 and PC_WE=1 in that same cycle, then go to DECODE; otherwise stay in FETCH.
REQ-025 DECODE: ALU_SrcB=11, Operation=000; next state by OpCode: 000000->RTEXE, 000100->BEQ, 001000->ADDIEXE, 100011 or 101011->MEMADR, 000010->JUMP, 000011->JAL, any other OpCode->FAULT.
REQ-026 MEMADR: ALU_SrcA=1, ALU_SrcB=10, Operation=000; next state MEMRD for OpCode 100011, MEMWR for 101011.
REQ-027 MEMRD: mem_req=1, IorD=1; on mem_ready go to MEMWB.
REQ-028 MEMWB: RF_WE=1, RF_WA_Sel=00, WD_Sel=01, instr_done=1; next state FETCH.
REQ-029 MEMWR: mem_req=1, IorD=1, WE_DM=1; on mem_ready assert instr_done=1 and go to FETCH.
REQ-030 RTEXE: ALU_SrcA=1, ALU_SrcB=00, Operation=010, next ALUWB; ALUWB: RF_WE=1, RF_WA_Sel=01, WD_Sel=00, instr_done=1, next FETCH.
REQ-031 BEQ: ALU_SrcA=1, ALU_SrcB=00, Operation=001, Branch=1, PC_Src=01, instr_done=1; next FETCH.
REQ-032 ADDIEXE: ALU_SrcA=1, ALU_SrcB=10, Operation=000, next ADDIWB; ADDIWB: RF_WE=1, RF_WA_Sel=00, WD_Sel=00, instr_done=1, next FETCH.
REQ-033 JUMP: PC_WE=1, PC_Src=10, instr_done=1; next FETCH.
REQ-034 JAL: PC_WE=1, PC_Src=10, RF_WE=1, RF_WA_Sel=10, WD_Sel=10 (the already-incremented PC), instr_done=1; next FETCH.
REQ-035 Wait counter, 8 bits: cleared on entry to FETCH, MEMRD or MEMWR; increments each cycle mem_req=1 and mem_ready=0.
REQ-036 Timeout: if MEM_TIMEOUT>0 and the counter equals MEM_TIMEOUT with mem_ready=0, go to FAULT; no enable pulses in that cycle.
REQ-037 mem_ready=1 in a non-memory state SHALL be ignored.
REQ-038 FAULT: fault=1 and all other outputs 0; exit only by reset.
REQ-039 Per-instruction cycle counts with zero memory wait: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, jal 3.

Reset
REQ-040 rst_n sampled low at a rising edge SHALL set state=FETCH and counter=0, and SHALL clear fault.
REQ-041 While rst_n is low, all enables (mem_req, IR_WE, PC_WE, Branch, WE_DM, RF_WE) and instr_done SHALL be forced to 0 combinationally.
REQ-042 Reset in any state, including mid-handshake, SHALL abandon the instruction with no further enable pulses.

Verification
REQ-043 Reset, then lw (100011) with mem_ready high every cycle -> states 0,1,2,3,4; RF_WE=1 and WD_Sel=01 in state 4; instr_done on cycle 5.
REQ-044 sw (101011) with mem_ready delayed 3 cycles in MEMWR -> WE_DM held 4 cycles; instr_done only on the ready cycle; then FETCH.
REQ-045 jal (000011) -> state 12 with PC_WE=1, RF_WA_Sel=10, WD_Sel=10 for one cycle; total 3 cycles.
REQ-046 OpCode 111111 in DECODE -> FAULT; fault=1 and holds for 20 cycles; rst_n low then fault=0 and state=0.
REQ-047 MEM_TIMEOUT=15 with mem_ready held low in FETCH -> 15 wait cycles, then FAULT; IR_WE never asserted.
REQ-048 rst_n low during MEMRD with mem_ready high in the same cycle -> no RF_WE; state=0 on the next cycle.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Handshake/control bundle between the multicycle controller and its datapath.
// The controller drives through the master modport; the datapath/memory side uses slave.
interface multicycle_ctrl_if;
  logic [5:0] OpCode;
  logic       mem_ready;
  logic       mem_req;
  logic       IorD;
  logic       IR_WE;
  logic       PC_WE;
  logic       Branch;
  logic [1:0] PC_Src;
  logic       ALU_SrcA;
  logic [1:0] ALU_SrcB;
  logic [2:0] Operation;
  logic       WE_DM;
  logic       RF_WE;
  logic [1:0] RF_WA_Sel;
  logic [1:0] WD_Sel;
  logic       instr_done;
  logic       fault;
  logic [3:0] state;

  modport master (
    input  OpCode, mem_ready,
    output mem_req, IorD, IR_WE, PC_WE, Branch, PC_Src, ALU_SrcA, ALU_SrcB,
           Operation, WE_DM, RF_WE, RF_WA_Sel, WD_Sel, instr_done, fault, state
  );

  modport slave (
    output OpCode, mem_ready,
    input  mem_req, IorD, IR_WE, PC_WE, Branch, PC_Src, ALU_SrcA, ALU_SrcB,
           Operation, WE_DM, RF_WE, RF_WA_Sel, WD_Sel, instr_done, fault, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit: Moore FSM sequencing fetch/decode/execute/
// write-back with a bounded memory handshake and a sticky fault state.
//
// state   | meaning
// FETCH   | read instruction at PC, IR and PC+4 written on mem_ready
// DECODE  | branch target precompute, dispatch on OpCode
// MEMADR  | effective address rs + imm
// MEMRD   | data memory read, wait for mem_ready
// MEMWB   | load data into rt
// MEMWR   | data memory write, wait for mem_ready
// RTEXE   | R-type ALU op on rs, rt
// ALUWB   | R-type result into rd
// BEQ     | compare rs/rt, conditional PC write
// ADDIEXE | rs + imm
// ADDIWB  | addi result into rt
// JUMP    | PC <- jump target
// JAL     | PC <- jump target, r31 <- PC
// FAULT   | illegal opcode or memory timeout, left only by reset
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTEXE   = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BEQ     = 4'd8;
  localparam logic [3:0] S_ADDIEXE = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
  localparam logic [3:0] S_JAL     = 4'd12;
  localparam logic [3:0] S_FAULT   = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);
  localparam bit         TIMEOUT_EN  = (MEM_TIMEOUT != 0);

  logic [3:0] state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;

  logic       mem_state;
  logic       timeout;

  logic       mem_req_c;
  logic       iord_c;
  logic       ir_we_c;
  logic       pc_we_c;
  logic       branch_c;
  logic [1:0] pc_src_c;
  logic       alu_src_a_c;
  logic [1:0] alu_src_b_c;
  logic [2:0] operation_c;
  logic       we_dm_c;
  logic       rf_we_c;
  logic [1:0] rf_wa_sel_c;
  logic [1:0] wd_sel_c;
  logic       instr_done_c;

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign timeout   = TIMEOUT_EN && mem_state && !bus.mem_ready && (wait_cnt_q == TIMEOUT_CNT);

  always_comb begin
    state_d      = state_q;
    mem_req_c    = 1'b0;
    iord_c       = 1'b0;
    ir_we_c      = 1'b0;
    pc_we_c      = 1'b0;
    branch_c     = 1'b0;
    pc_src_c     = 2'b00;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    operation_c  = 3'b000;
    we_dm_c      = 1'b0;
    rf_we_c      = 1'b0;
    rf_wa_sel_c  = 2'b00;
    wd_sel_c     = 2'b00;
    instr_done_c = 1'b0;

    case (state_q)
      S_FETCH: begin
        alu_src_b_c = 2'b01;
        if (timeout) begin
          state_d = S_FAULT;
        end else begin
          mem_req_c = 1'b1;
          if (bus.mem_ready) begin
            ir_we_c = 1'b1;
            pc_we_c = 1'b1;
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        alu_src_b_c = 2'b11;
        case (bus.OpCode)
          OP_RTYPE:     state_d = S_RTEXE;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEXE;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_J:         state_d = S_JUMP;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        // OpCode is only re-checked here; anything that stopped being a load/store faults
        if (bus.OpCode == OP_LW)      state_d = S_MEMRD;
        else if (bus.OpCode == OP_SW) state_d = S_MEMWR;
        else                          state_d = S_FAULT;
      end
      S_MEMRD: begin
        iord_c = 1'b1;
        if (timeout) begin
          state_d = S_FAULT;
        end else begin
          mem_req_c = 1'b1;
          if (bus.mem_ready) state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        rf_we_c      = 1'b1;
        wd_sel_c     = 2'b01;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        iord_c = 1'b1;
        if (timeout) begin
          state_d = S_FAULT;
        end else begin
          mem_req_c = 1'b1;
          we_dm_c   = 1'b1;
          if (bus.mem_ready) begin
            instr_done_c = 1'b1;
            state_d      = S_FETCH;
          end
        end
      end
      S_RTEXE: begin
        alu_src_a_c = 1'b1;
        operation_c = 3'b010;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we_c      = 1'b1;
        rf_wa_sel_c  = 2'b01;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a_c  = 1'b1;
        operation_c  = 3'b001;
        branch_c     = 1'b1;
        pc_src_c     = 2'b01;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_ADDIEXE: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: begin
        rf_we_c      = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_JUMP: begin
        pc_we_c      = 1'b1;
        pc_src_c     = 2'b10;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_JAL: begin
        pc_we_c      = 1'b1;
        pc_src_c     = 2'b10;
        rf_we_c      = 1'b1;
        rf_wa_sel_c  = 2'b10;
        wd_sel_c     = 2'b10;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  // Wait count restarts whenever the state changes, so each handshake starts from zero
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = 8'd0;
    end else if (mem_req_c && !bus.mem_ready && (wait_cnt_q != 8'hFF)) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign bus.mem_req    = mem_req_c & rst_n;
  assign bus.IR_WE      = ir_we_c & rst_n;
  assign bus.PC_WE      = pc_we_c & rst_n;
  assign bus.Branch     = branch_c & rst_n;
  assign bus.WE_DM      = we_dm_c & rst_n;
  assign bus.RF_WE      = rf_we_c & rst_n;
  assign bus.instr_done = instr_done_c & rst_n;
  assign bus.IorD       = iord_c;
  assign bus.PC_Src     = pc_src_c;
  assign bus.ALU_SrcA   = alu_src_a_c;
  assign bus.ALU_SrcB   = alu_src_b_c;
  assign bus.Operation  = operation_c;
  assign bus.RF_WA_Sel  = rf_wa_sel_c;
  assign bus.WD_Sel     = wd_sel_c;
  assign bus.fault      = (state_q == S_FAULT);
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction-level model expands each
// instruction into its expected per-cycle control vectors.
module tb_multicycle_ctrl;
  localparam int TMO = 15;

  typedef struct packed {
    logic [3:0] state;
    logic       fault;
    logic       instr_done;
    logic       mem_req;
    logic       IorD;
    logic       IR_WE;
    logic       PC_WE;
    logic       Branch;
    logic [1:0] PC_Src;
    logic       ALU_SrcA;
    logic [1:0] ALU_SrcB;
    logic [2:0] Operation;
    logic       WE_DM;
    logic       RF_WE;
    logic [1:0] RF_WA_Sel;
    logic [1:0] WD_Sel;
  } ovec_t;

  typedef struct packed {
    logic [3:0] st;
    logic       done;
    logic       wedm;
    logic       irwe;
    logic       rfwe;
  } tr_t;

  localparam int F_ST = 0, F_DONE = 1, F_WEDM = 2, F_IRWE = 3, F_RFWE = 4;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  tr_t  trace[$];

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Control word each state must present, straight from the per-state output list
  function automatic ovec_t spec_out(input int st, input bit rdy, input bit tmo, input bit rst);
    ovec_t o;
    o = '0;
    o.state = 4'(st);
    case (st)
      0: begin
        o.mem_req = 1'b1; o.ALU_SrcB = 2'b01;
        if (rdy) begin o.IR_WE = 1'b1; o.PC_WE = 1'b1; end
      end
      1: o.ALU_SrcB = 2'b11;
      2: begin o.ALU_SrcA = 1'b1; o.ALU_SrcB = 2'b10; end
      3: begin o.mem_req = 1'b1; o.IorD = 1'b1; end
      4: begin o.RF_WE = 1'b1; o.WD_Sel = 2'b01; o.instr_done = 1'b1; end
      5: begin
        o.mem_req = 1'b1; o.IorD = 1'b1; o.WE_DM = 1'b1;
        if (rdy) o.instr_done = 1'b1;
      end
      6: begin o.ALU_SrcA = 1'b1; o.Operation = 3'b010; end
      7: begin o.RF_WE = 1'b1; o.RF_WA_Sel = 2'b01; o.instr_done = 1'b1; end
      8: begin
        o.ALU_SrcA = 1'b1; o.Operation = 3'b001; o.Branch = 1'b1;
        o.PC_Src = 2'b01; o.instr_done = 1'b1;
      end
      9: begin o.ALU_SrcA = 1'b1; o.ALU_SrcB = 2'b10; end
      10: begin o.RF_WE = 1'b1; o.instr_done = 1'b1; end
      11: begin o.PC_WE = 1'b1; o.PC_Src = 2'b10; o.instr_done = 1'b1; end
      12: begin
        o.PC_WE = 1'b1; o.PC_Src = 2'b10; o.RF_WE = 1'b1;
        o.RF_WA_Sel = 2'b10; o.WD_Sel = 2'b10; o.instr_done = 1'b1;
      end
      15: o.fault = 1'b1;
      default: ;
    endcase
    if (tmo) begin
      o.mem_req = 1'b0; o.IR_WE = 1'b0; o.PC_WE = 1'b0; o.WE_DM = 1'b0; o.instr_done = 1'b0;
    end
    if (rst) begin
      o.mem_req = 1'b0; o.IR_WE = 1'b0; o.PC_WE = 1'b0; o.Branch = 1'b0;
      o.WE_DM = 1'b0; o.RF_WE = 1'b0; o.instr_done = 1'b0;
    end
    return o;
  endfunction

  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // One clock cycle: drive inputs, compare all outputs mid-cycle, record a trace entry
  task automatic apply(input int st, input bit rdy, input bit tmo, input bit rst);
    ovec_t e, a;
    tr_t   t;
    rst_n = ~rst;
    bus.mem_ready = rdy;
    e = spec_out(st, rdy, tmo, rst);
    @(negedge clk);
    a.state = bus.state;         a.fault = bus.fault;       a.instr_done = bus.instr_done;
    a.mem_req = bus.mem_req;     a.IorD = bus.IorD;         a.IR_WE = bus.IR_WE;
    a.PC_WE = bus.PC_WE;         a.Branch = bus.Branch;     a.PC_Src = bus.PC_Src;
    a.ALU_SrcA = bus.ALU_SrcA;   a.ALU_SrcB = bus.ALU_SrcB; a.Operation = bus.Operation;
    a.WE_DM = bus.WE_DM;         a.RF_WE = bus.RF_WE;       a.RF_WA_Sel = bus.RF_WA_Sel;
    a.WD_Sel = bus.WD_Sel;
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL cycle_outputs model_state=%0d rdy=%0d rst=%0d: got %h, expected %h",
               st, rdy, rst, a, e);
    end
    t.st = bus.state; t.done = bus.instr_done; t.wedm = bus.WE_DM;
    t.irwe = bus.IR_WE; t.rfwe = bus.RF_WE;
    trace.push_back(t);
    @(posedge clk);
    #1;
  endtask

  // Expands one instruction into its state walk; memory phases wait 'wt' cycles.
  // abort_st >= 0 pulls reset (with mem_ready high) on entry to that phase.
  task automatic exec(input logic [5:0] op, input int wt, input int abort_st, input bit nm_rdy);
    int seq[$];
    trace.delete();
    bus.OpCode = op;
    case (op)
      6'b100011: seq = '{0, 1, 2, 3, 4};
      6'b101011: seq = '{0, 1, 2, 5};
      6'b000000: seq = '{0, 1, 6, 7};
      6'b001000: seq = '{0, 1, 9, 10};
      6'b000100: seq = '{0, 1, 8};
      6'b000010: seq = '{0, 1, 11};
      6'b000011: seq = '{0, 1, 12};
      default:   seq = '{0, 1, 15};
    endcase
    foreach (seq[k]) begin
      if (seq[k] == abort_st) begin
        apply(seq[k], 1'b1, 1'b0, 1'b1);
        return;
      end
      if (seq[k] == 15) return;
      if (seq[k] == 0 || seq[k] == 3 || seq[k] == 5) begin
        for (int i = 0; i < wt; i++) begin
          if (TMO != 0 && i == TMO) begin
            apply(seq[k], 1'b0, 1'b1, 1'b0);
            return;
          end
          apply(seq[k], 1'b0, 1'b0, 1'b0);
        end
        apply(seq[k], 1'b1, 1'b0, 1'b0);
      end else begin
        apply(seq[k], nm_rdy, 1'b0, 1'b0);
      end
    end
  endtask

  function automatic int tr_count(input int fld, input int val);
    int n = 0;
    foreach (trace[k]) begin
      int v;
      case (fld)
        F_ST:    v = int'(trace[k].st);
        F_DONE:  v = int'(trace[k].done);
        F_WEDM:  v = int'(trace[k].wedm);
        F_IRWE:  v = int'(trace[k].irwe);
        default: v = int'(trace[k].rfwe);
      endcase
      if (v == val) n++;
    end
    return n;
  endfunction

  function automatic int cycles_to_done();
    foreach (trace[k]) if (trace[k].done) return k + 1;
    return -1;
  endfunction

  task automatic hold_fault(input int n);
    for (int i = 0; i < n; i++) apply(15, i[0], 1'b0, 1'b0);
  endtask

  initial begin
    int lw_exp[5];
    lw_exp = '{0, 1, 2, 3, 4};
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    bus.OpCode = 6'b000000;
    @(posedge clk);
    #1;
    apply(0, 1'b1, 1'b0, 1'b1);
    check("reset_state", int'(bus.state), 0);
    check("reset_fault", int'(bus.fault), 0);

    exec(6'b100011, 0, -1, 1'b1);
    foreach (lw_exp[k]) check("lw_state_seq", int'(trace[k].st), lw_exp[k]);
    check("lw_cycles", cycles_to_done(), 5);
    check("lw_rf_we_in_memwb", int'(trace[4].rfwe), 1);

    exec(6'b101011, 3, -1, 1'b0);
    check("sw_we_dm_cycles", tr_count(F_WEDM, 1), 4);
    check("sw_done_pulses", tr_count(F_DONE, 1), 1);
    check("sw_cycles", cycles_to_done(), 10);

    exec(6'b000000, 0, -1, 1'b1);
    check("rtype_cycles", cycles_to_done(), 4);
    exec(6'b001000, 0, -1, 1'b0);
    check("addi_cycles", cycles_to_done(), 4);
    exec(6'b000100, 0, -1, 1'b1);
    check("beq_cycles", cycles_to_done(), 3);
    exec(6'b000010, 0, -1, 1'b0);
    check("j_cycles", cycles_to_done(), 3);
    exec(6'b000011, 0, -1, 1'b1);
    check("jal_cycles", cycles_to_done(), 3);
    check("jal_state", int'(trace[2].st), 12);
    exec(6'b101011, 0, -1, 1'b0);
    check("sw_nowait_cycles", cycles_to_done(), 4);

    exec(6'b101011, TMO, -1, 1'b1);
    check("sw_wait_limit_cycles", cycles_to_done(), 34);
    check("sw_wait_limit_fault", int'(bus.fault), 0);

    exec(6'b100011, 0, 3, 1'b1);
    check("abort_memrd_rf_we", tr_count(F_RFWE, 1), 0);
    check("abort_memrd_state", int'(bus.state), 0);

    exec(6'b101011, 2, 0, 1'b1);
    check("abort_fetch_state", int'(bus.state), 0);

    exec(6'b111111, 0, -1, 1'b1);
    check("illegal_fault", int'(bus.fault), 1);
    hold_fault(20);
    apply(15, 1'b0, 1'b0, 1'b1);
    check("illegal_fault_cycles", tr_count(F_ST, 15), 21);
    check("illegal_reset_state", int'(bus.state), 0);
    check("illegal_reset_fault", int'(bus.fault), 0);

    exec(6'b100011, 100, -1, 1'b0);
    check("tmo_fetch_cycles", tr_count(F_ST, 0), TMO + 1);
    check("tmo_ir_we", tr_count(F_IRWE, 1), 0);
    check("tmo_fault", int'(bus.fault), 1);
    hold_fault(3);
    apply(15, 1'b1, 1'b0, 1'b1);
    check("tmo_reset_state", int'(bus.state), 0);

    exec(6'b100011, 1, -1, 1'b1);
    check("recover_lw_cycles", cycles_to_done(), 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
